// File: rtl/mips_div_pkg.sv
// ============================================================================
// Module      : mips_div_pkg
// Description : Shared state encoding and constants for the MIPS DIV/DIVU unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // Default datapath width; one restoring step per quotient bit.
    localparam int DIV_STEPS = 32;

    // Quotient produced for a zero divisor (all ones, sliced to WIDTH).
    localparam logic [63:0] DIV_DBZ_QUO = '1;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_neg;

    // One guard bit above the remainder makes the trial sign unambiguous.
    assign w_shift  = {rem, quo[WIDTH-1]};
    assign w_trial  = w_shift - {2'b00, divisor};
    assign w_neg    = w_trial[WIDTH+1];

    assign rem_next = w_neg ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
    assign quo_next = {quo[WIDTH-2:0], ~w_neg};

endmodule

`default_nettype wire

// File: rtl/mips_div_unit.sv
// ============================================================================
// Module      : mips_div_unit
// Description : Multi-cycle restoring DIV/DIVU for the EX stage; writes HI/LO
//               and stalls the upstream pipeline. Optional macro:
//               MIPS_DIV_EARLY_OUT_EN (skip iteration for b=0 or |a|<|b|).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_div_unit
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_STEPS,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_qneg;
    logic             r_rneg;

    logic             w_go;
    logic             w_last;
    logic             w_qneg_in;
    logic             w_rneg_in;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;

    assign w_go      = start & ~annul;
    assign w_last    = (r_count == CNT_W'(WIDTH - 1));
    assign w_qneg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign w_rneg_in = is_signed & a[WIDTH-1];
    assign w_a_abs   = (is_signed & a[WIDTH-1]) ? -a : a;
    assign w_b_abs   = (is_signed & b[WIDTH-1]) ? -b : b;

    div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_div),
        .rem_next (w_rem_nx),
        .quo_next (w_quo_nx)
    );

    // Sign fixup folded onto the final step so it registers on entry to DONE.
    assign w_lo_fix = r_qneg ? -w_quo_nx : w_quo_nx;
    assign w_hi_fix = r_rneg ? -w_rem_nx[WIDTH-1:0] : w_rem_nx[WIDTH-1:0];

`ifdef MIPS_DIV_EARLY_OUT_EN
    logic             w_early;
    logic [WIDTH-1:0] w_eo_quo;
    logic [WIDTH-1:0] w_eo_lo;
    logic [WIDTH-1:0] w_eo_hi;

    assign w_early  = (w_b_abs == '0) | (w_a_abs < w_b_abs);
    assign w_eo_quo = (w_b_abs == '0) ? DIV_DBZ_QUO[WIDTH-1:0] : '0;
    assign w_eo_lo  = w_qneg_in ? -w_eo_quo : w_eo_quo;
    assign w_eo_hi  = w_rneg_in ? -w_a_abs : w_a_abs;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_ready <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_rem   <= '0;
                        r_quo   <= w_a_abs;
                        r_div   <= w_b_abs;
                        r_qneg  <= w_qneg_in;
                        r_rneg  <= w_rneg_in;
                        r_count <= '0;
`ifdef MIPS_DIV_EARLY_OUT_EN
                        if (w_early) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_lo    <= w_eo_lo;
                            r_hi    <= w_eo_hi;
                        end else begin
                            r_state <= S_BUSY;
                        end
`else
                        r_state <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (annul) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem   <= w_rem_nx;
                        r_quo   <= w_quo_nx;
                        r_count <= r_count + CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_lo    <= w_lo_fix;
                            r_hi    <= w_hi_fix;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A flush releases the pipeline in the same cycle it is seen.
    assign stall = ~annul & (((r_state == S_IDLE) & start) | (r_state == S_BUSY));
    assign ready = r_ready;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mips_div_unit.sv
// ============================================================================
// Module      : tb_mips_div_unit
// Description : Randomised scoreboard bench for mips_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_div_unit #(
        .WIDTH     (32),
        .CNT_W     (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .annul     (annul),
        .a         (a),
        .b         (b),
        .stall     (stall),
        .ready     (ready),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          rdy_cyc;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Architectural reference: MIPS truncating division, no trap cases.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                                  output logic [31:0] mlo, output logic [31:0] mhi, output int mlat);
        int          sa;
        int          sb;
        logic [31:0] aa;
        logic [31:0] bb;
        if (mb == 0) begin
            mlo = (ms && ma[31]) ? 32'd1 : 32'hFFFF_FFFF;
            mhi = ma;
        end else if (!ms) begin
            mlo = ma / mb;
            mhi = ma % mb;
        end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
            mlo = 32'h8000_0000;
            mhi = 32'h0;
        end else begin
            sa  = ma;
            sb  = mb;
            mlo = sa / sb;
            mhi = sa % sb;
        end
        aa = (ms && ma[31]) ? -ma : ma;
        bb = (ms && mb[31]) ? -mb : mb;
`ifdef MIPS_DIV_EARLY_OUT_EN
        mlat = (bb == 0 || aa < bb) ? 1 : 33;
`else
        mlat = (aa == bb) ? 33 : 33;
`endif
    endfunction

    task automatic push_exp(input logic [31:0] pa, input logic [31:0] pb, input logic ps, input int n);
        exp_t e;
        model(pa, pb, ps, e.lo, e.hi, e.lat);
        e.rdy_cyc = n + e.lat;
        sbq.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst || annul) begin
            stall_cnt = 0;
        end else if (ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready=1 want no result (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("lo", lo, mon_e.lo);
                chk("hi", hi, mon_e.hi);
                chk("ready_cycle", cyc, mon_e.rdy_cyc);
                chk("stall_cycles", stall_cnt, mon_e.lat);
                chk("stall_at_ready", {31'b0, stall}, 32'd0);
                last_lo = mon_e.lo;
                last_hi = mon_e.hi;
            end
            stall_cnt = 0;
            done_cnt++;
        end else if (stall) begin
            stall_cnt++;
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input bit push, output int n);
        @(posedge clk);
        #1;
        a         = ia;
        b         = ib;
        is_signed = is;
        start     = 1'b1;
        n         = cyc;
        if (push) push_exp(ia, ib, is, n);
        #1;
        chk("stall_issue", {31'b0, stall}, 32'd1);
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 100 && done_cnt == prev; i++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt == prev) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no ready want ready within 100 cycles");
        end
    endtask

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic is);
        int n;
        int prev;
        prev = done_cnt;
        issue(ia, ib, is, 1'b1, n);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(prev);
    endtask

    initial begin
        int          n;
        int          prev;
        int          lat1;
        logic [31:0] t_lo;
        logic [31:0] t_hi;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; annul = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'd5, 32'd0, 1'b0);
        run_op(32'd3, 32'd10, 1'b0);
        run_op(32'd9, 32'd0, 1'b0);
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1);

        // Flush at iteration count 10: no result, HI/LO untouched.
        issue(32'h1234_5678, 32'd3, 1'b0, 1'b0, n);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        #1;
        chk("stall_annul", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        #1;
        chk("annul_ready", {31'b0, ready}, 32'd0);
        chk("annul_hi", hi, last_hi);
        chk("annul_lo", lo, last_lo);
        run_op(32'd1000, 32'd33, 1'b0);

        // start held through BUSY/DONE retriggers only at the next IDLE sample.
        prev = done_cnt;
        issue(32'd77777, 32'd13, 1'b0, 1'b1, n);
        model(32'd77777, 32'd13, 1'b0, t_lo, t_hi, lat1);
        wait_done(prev);
        push_exp(32'd77777, 32'd13, 1'b0, n + lat1 + 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(prev + 1);

        // Reset mid-operation.
        issue(32'hDEAD_BEEF, 32'd7, 1'b0, 1'b0, n);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        last_hi = '0;
        last_lo = '0;

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = $urandom;
                default: begin ra = $urandom_range(0, 50); rb = $urandom_range(51, 500); end
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (40) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_div_unit.md
Name: mips_div_unit

Overview:
- Multi-cycle radix-2 restoring divider executing MIPS DIV/DIVU in the EX stage.
- Writes the HI/LO pair and drives the stall signal.
- The stall signal gates the enables of the upstream PC and IF/ID/ID/EX pipeline registers.
- Holds the pipeline frozen until the quotient and remainder are ready, then releases it.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock, shared with all pipeline registers.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX-stage DIV/DIVU valid; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- annul  input  1  flush of the EX instruction; aborts any operation.
- a  input  WIDTH  dividend (rs); sampled with start.
- b  input  WIDTH  divisor (rt); sampled with start.
- stall  output  1  to hazard unit; deasserts the upstream flop enables.
- ready  output  1  one-cycle pulse; hi/lo valid and written to HI/LO this cycle.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.

Behaviour:
- Reset: one clk edge with rst=1 sets:
  - state=IDLE, count=0, ready=0, hi=0, lo=0;
  - internal dividend, divisor and sign registers to 0.
- rst has priority over every other input.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and annul=0 at edge N latches operands and goes to BUSY.
  - Signed mode latches absolute values, plus q_neg = a[W-1]^b[W-1] and r_neg = a[W-1].
  - Unsigned mode clears both sign flags.
- BUSY:
  - One restoring step per cycle: shift {rem,quo} left by 1, trial-subtract the divisor from rem.
  - If the trial result is non-negative, keep it and set quo[0]=1.
  - rem is WIDTH+1 bits internally.
  - count increments each cycle; after exactly WIDTH steps (edge N+WIDTH) the state goes to DONE.
- DONE:
  - Lasts one cycle (cycle N+WIDTH+1) with ready=1.
  - Sign fixup is registered on entry to DONE: lo = q_neg ? -quo : quo, hi = r_neg ? -rem : rem.
  - Next edge returns to IDLE.
- Latency: start in cycle N gives ready in cycle N+WIDTH+1 (33 cycles for WIDTH=32).
- stall = (IDLE & start & ~annul) | BUSY.
  - It is combinational so the issuing instruction freezes in its start cycle.
  - stall=0 in DONE, so the pipeline advances in the same cycle as the ready pulse.
- hi/lo hold their last value until the next DONE.
- start in BUSY/DONE is ignored; the start bit is held by the frozen ID/EX register.
- annul in any state: next edge goes to IDLE and ready stays 0.
  - hi/lo are unchanged, and stall drops combinationally in that cycle.
- Divide by zero (b=0), performed as a full-length operation:
  - unsigned: lo=all ones, hi=a;
  - signed: sign fixup applied to those magnitudes, e.g. a=5 gives lo=0xFFFFFFFF, hi=5.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no trap).
- Back-to-back: start may be accepted in the IDLE cycle directly following DONE.

Optional Feature:
- Macro name: MIPS_DIV_EARLY_OUT_EN.
- Defined:
  - If the latched divisor is 0, or the absolute dividend is less than the absolute divisor, BUSY is skipped.
  - IDLE goes directly to DONE; ready arrives in cycle N+1.
  - Results are unchanged (b=0 → values above; |a|<|b| → lo=0, hi=a).
  - stall is high for cycle N only.
- Not defined: every operation takes the full WIDTH steps; no comparator is built.

Decomposition:
- Package mips_div_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - localparam DIV_STEPS = WIDTH;
  - the divide-by-zero quotient constant (all ones).
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once and iterated by the FSM.

Test Plan:
- Unsigned 100/7 → after 33 cycles: ready pulse, lo=14, hi=2.
  - stall high cycles N..N+32, low in the ready cycle.
- Signed -7/2 (0xFFFFFFF9 / 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Also 7/-2 → lo=0xFFFFFFFD, hi=1.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Also unsigned 5/0 → lo=0xFFFFFFFF, hi=5.
- annul asserted at BUSY count=10 → IDLE next cycle, no ready, hi/lo keep previous values.
  - A new start 1 cycle later completes correctly.
- rst pulsed mid-BUSY → next cycle: state IDLE, ready=0, hi=lo=0, stall=0.
  - start held high through BUSY/DONE does not retrigger an operation; only the next IDLE sample does.
- MIPS_DIV_EARLY_OUT_EN defined: 3/10 → ready in cycle N+1, lo=0, hi=3.
  - Also 9/0 → ready in cycle N+1, lo=0xFFFFFFFF, hi=9.
